aes_round_sequencer: RTL and testbench

- Iterative control FSM that runs one block through NR AES rounds on a single shared combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey and their inverses), one round per clock.
- Holds the state register and the round counter, and drives the round-key index into the external key-schedule store.
- Decides per cycle whether the datapath runs a normal or a final round, in the forward or the inverse direction.
- Sits between the block-level valid/ready interface and the round datapath instance.

---
 rtl/aes_round_sequencer_pkg.sv | 25 ++
 rtl/aes_round_sequencer.sv | 104 ++++++++++
 tb/tb_aes_round_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES types and constants for the iterative round sequencer.
// The round datapath and key store sit outside and exchange state_t/roundKey_t words.
package aes_round_sequencer_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] roundKey_t;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } seq_state_t;

  // Round count for a key of nk 32-bit words (4/6/8).
  function automatic int nr_for_nk(input int nk);
    return (nk == 4) ? NR_AES128 : (nk == 6) ? NR_AES192 : NR_AES256;
  endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: holds state/round counter, drives the key index
// and tells the external shared round datapath which round flavour to run.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int NR    = NR_AES128,
  parameter int IDX_W = 4            // 2**IDX_W must exceed NR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  state_t           in_block,
  input  logic             in_decrypt,
  input  logic             abort,
  output logic [IDX_W-1:0] rk_index,
  input  roundKey_t        rk_data,
  output state_t           round_in,
  output logic             round_final,
  output logic             round_decrypt,
  input  state_t           round_out,
  output logic             out_valid,
  input  logic             out_ready,
  output state_t           out_block,
  output logic             busy
);

  localparam logic [IDX_W-1:0] NR_I  = IDX_W'(NR);
  localparam logic [IDX_W-1:0] NR_M1 = IDX_W'(NR - 1);

  seq_state_t       st, st_nxt;
  state_t           state_reg, state_nxt;
  logic [IDX_W-1:0] round_ctr, ctr_nxt;
  logic             dir_reg, dir_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      state_reg <= '0;
      round_ctr <= '0;
      dir_reg   <= 1'b0;
    end else begin
      st        <= st_nxt;
      state_reg <= state_nxt;
      round_ctr <= ctr_nxt;
      dir_reg   <= dir_nxt;
    end
  end

  // rk_index/round_final depend only on st/round_ctr/dir_reg, never on inputs.
  always_comb begin
    st_nxt      = st;
    state_nxt   = state_reg;
    ctr_nxt     = round_ctr;
    dir_nxt     = dir_reg;
    rk_index    = '0;
    round_final = 1'b0;
    case (st)
      IDLE: begin
        if (in_valid && !abort) begin
          state_nxt = in_block;
          dir_nxt   = in_decrypt;
          ctr_nxt   = IDX_W'(1);
          st_nxt    = INIT;
        end
      end
      INIT: begin
        rk_index  = dir_reg ? NR_I : '0;
        state_nxt = state_reg ^ rk_data;
        st_nxt    = (NR == 1) ? FINAL : ROUND;
      end
      ROUND: begin
        rk_index  = dir_reg ? (NR_I - round_ctr) : round_ctr;
        state_nxt = round_out;
        ctr_nxt   = round_ctr + IDX_W'(1);
        if (round_ctr == NR_M1) st_nxt = FINAL;
      end
      FINAL: begin
        rk_index    = dir_reg ? '0 : NR_I;
        round_final = 1'b1;
        state_nxt   = round_out;
        st_nxt      = DONE;
      end
      DONE: begin
        if (out_ready) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    // Flush wins over everything, including a DONE handshake.
    if (abort && st != IDLE) begin
      st_nxt    = IDLE;
      state_nxt = '0;
      ctr_nxt   = '0;
    end
  end

  assign in_ready      = (st == IDLE);
  assign out_valid     = (st == DONE);
  assign busy          = (st != IDLE);
  assign round_in      = state_reg;
  assign out_block     = state_reg;
  assign round_decrypt = dir_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: NR=10 and NR=14 instances, each with a behavioural
// AES round datapath and key store alongside, checked against FIPS-197 vectors.
module tb_aes_round_sequencer;
  import aes_round_sequencer_pkg::*;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid [2];
  logic         in_ready [2];
  logic [127:0] in_block [2];
  logic         in_decrypt [2];
  logic         abort [2];
  logic [3:0]   rk_index [2];
  logic [127:0] rk_data [2];
  logic [127:0] round_in [2];
  logic         round_final [2];
  logic         round_decrypt [2];
  logic [127:0] round_out [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_block [2];
  logic         busy [2];

  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] keys [2][16];
  int           hs [2] = '{0, 0};
  int           nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10), .IDX_W(4)) dut10 (
    .clock(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(in_block[0]), .in_decrypt(in_decrypt[0]), .abort(abort[0]),
    .rk_index(rk_index[0]), .rk_data(rk_data[0]), .round_in(round_in[0]),
    .round_final(round_final[0]), .round_decrypt(round_decrypt[0]),
    .round_out(round_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_block(out_block[0]), .busy(busy[0]));

  aes_round_sequencer #(.NR(14), .IDX_W(4)) dut14 (
    .clock(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(in_block[1]), .in_decrypt(in_decrypt[1]), .abort(abort[1]),
    .rk_index(rk_index[1]), .rk_data(rk_data[1]), .round_in(round_in[1]),
    .round_final(round_final[1]), .round_decrypt(round_decrypt[1]),
    .round_out(round_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_block(out_block[1]), .busy(busy[1]));

  // ---------------- GF(2^8) helpers and round datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gm(r, a);
    return r ^ rl(r, 1) ^ rl(r, 2) ^ rl(r, 3) ^ rl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic fin, input logic dec);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] m [4];
    logic [7:0] o;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        t[row+4*c] = dec ? isb[b[row+4*((c-row+4)%4)]] : sb[b[row+4*((c+row)%4)]];
    if (dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    if (!fin) begin
      m = dec ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          o = 8'h00;
          for (int j = 0; j < 4; j++) o = o ^ gm(t[j+4*c], m[(j-row+4)%4]);
          b[row+4*c] = o;
        end
      end
      for (int i = 0; i < 16; i++) t[i] = b[i];
    end
    if (!dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rk_data[i]   = keys[i][rk_index[i]];
      round_out[i] = round_fn(round_in[i], rk_data[i], round_final[i], round_decrypt[i]);
    end
  end

  task automatic expand(input int sel, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nr_for_nk(nk);
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4)
          t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int j = 0; j < 16; j++)
      keys[sel][j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
  endtask

  // Handshakes that count as delivered results; abort cancels a coincident one.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (out_valid[i] && out_ready[i] && !abort[i]) hs[i] <= hs[i] + 1;

  // ---------------- checking ----------------
  task automatic chk(input logic [127:0] a, input logic [127:0] e, input string nm);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chkb(input logic a, input logic e, input string nm);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chki(input int a, input int e, input string nm);
    nchk++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chkb(in_ready[0], 1'b1, {tag, " in_ready"});
    chkb(out_valid[0], 1'b0, {tag, " out_valid"});
    chkb(busy[0], 1'b0, {tag, " busy"});
    chki(int'(rk_index[0]), 0, {tag, " rk_index"});
    chkb(round_final[0], 1'b0, {tag, " round_final"});
    chkb(round_decrypt[0], 1'b0, {tag, " round_decrypt"});
    chk(round_in[0], 128'h0, {tag, " round_in"});
    chk(out_block[0], 128'h0, {tag, " out_block"});
  endtask

  task automatic run_block(input int sel, input logic dec, input logic [127:0] din,
                           input logic [127:0] dout, input string tag);
    int nr, h, idx;
    nr = nr_for_nk(sel == 0 ? 4 : 8);
    @(posedge clk); #1;
    h = hs[sel];
    in_valid[sel] = 1'b1; in_block[sel] = din; in_decrypt[sel] = dec; out_ready[sel] = 1'b1;
    @(negedge clk);
    chkb(in_ready[sel], 1'b1, {tag, " in_ready"});
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    in_block[sel] = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt[sel] = ~dec;
    for (int k = 1; k <= nr + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk(round_in[sel], din, {tag, " round_in load"});
        chkb(round_decrypt[sel], dec, {tag, " round_decrypt"});
      end
      if (k <= nr + 1) begin
        idx = dec ? nr - k + 1 : k - 1;
        chki(int'(rk_index[sel]), idx, $sformatf("%s rk_index c%0d", tag, k));
        chkb(round_final[sel], k == nr + 1, $sformatf("%s round_final c%0d", tag, k));
        chkb(out_valid[sel], 1'b0, $sformatf("%s out_valid early c%0d", tag, k));
      end else begin
        chkb(out_valid[sel], 1'b1, {tag, " out_valid latency"});
        chk(out_block[sel], dout, {tag, " out_block"});
      end
    end
    @(negedge clk);
    chkb(busy[sel], 1'b0, {tag, " busy after"});
    chki(hs[sel], h + 1, {tag, " handshakes"});
  endtask

  typedef struct {
    int           sel;
    logic         dec;
    logic [127:0] din;
    logic [127:0] dout;
    string        tag;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    logic seen;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    tbl[0] = '{0, 1'b0, PT,  CT1, "c1_enc"};
    tbl[1] = '{0, 1'b1, CT1, PT,  "c1_dec"};
    tbl[2] = '{1, 1'b0, PT,  CT3, "c3_enc"};
    tbl[3] = '{1, 1'b1, CT3, PT,  "c3_dec"};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_block[i] = '0; in_decrypt[i] = 1'b0;
      abort[i] = 1'b0; out_ready[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_held");
    reset = 1'b0;
    @(negedge clk);
    chk_reset("reset_released");

    foreach (tbl[i]) run_block(tbl[i].sel, tbl[i].dec, tbl[i].din, tbl[i].dout, tbl[i].tag);

    // Backpressure in DONE with a second block waiting.
    @(posedge clk); #1;
    h = hs[0];
    in_valid[0] = 1'b1; in_block[0] = PT; in_decrypt[0] = 1'b0; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_block[0] = CT1; in_decrypt[0] = 1'b1;
    repeat (11) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb(out_valid[0], 1'b1, $sformatf("bp out_valid s%0d", i));
      chk(out_block[0], CT1, $sformatf("bp out_block s%0d", i));
      chkb(in_ready[0], 1'b0, $sformatf("bp in_ready s%0d", i));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chkb(in_ready[0], 1'b1, "bp idle in_ready");
    chki(hs[0], h + 1, "bp first handshake");
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (11) @(negedge clk);
    chkb(out_valid[0], 1'b0, "bp second out_valid c11");
    @(negedge clk);
    chkb(out_valid[0], 1'b1, "bp second out_valid c12");
    chk(out_block[0], PT, "bp second out_block");
    @(negedge clk);
    chki(hs[0], h + 2, "bp second handshake");

    // Abort in ROUND with round_ctr = 4.
    @(posedge clk); #1;
    h = hs[0];
    in_valid[0] = 1'b1; in_block[0] = PT; in_decrypt[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(negedge clk);
    chki(int'(rk_index[0]), 4, "abort rk_index");
    @(posedge clk); #1;
    abort[0] = 1'b0;
    @(negedge clk);
    chkb(busy[0], 1'b0, "abort busy");
    chkb(in_ready[0], 1'b1, "abort in_ready");
    chk(out_block[0], 128'h0, "abort state cleared");
    seen = 1'b0;
    repeat (14) begin @(negedge clk); seen = seen | out_valid[0]; end
    chkb(seen, 1'b0, "abort no out_valid");
    chki(hs[0], h, "abort handshakes");
    run_block(0, 1'b0, PT, CT1, "post_abort");

    // Abort in IDLE beats in_valid.
    @(posedge clk); #1;
    in_valid[0] = 1'b1; in_block[0] = PT; abort[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    chkb(busy[0], 1'b0, "idle abort no accept");

    // Abort coincident with out_ready in DONE.
    @(posedge clk); #1;
    h = hs[0];
    in_valid[0] = 1'b1; in_block[0] = PT; in_decrypt[0] = 1'b0; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chkb(out_valid[0], 1'b1, "done_abort out_valid before");
    abort[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    @(negedge clk);
    chkb(out_valid[0], 1'b0, "done_abort out_valid after");
    chkb(busy[0], 1'b0, "done_abort busy");
    chk(out_block[0], 128'h0, "done_abort state cleared");
    chki(hs[0], h, "done_abort handshakes");

    // Async reset pulse between edges during FINAL.
    @(posedge clk); #1;
    h = hs[0];
    in_valid[0] = 1'b1; in_block[0] = PT; in_decrypt[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chkb(round_final[0], 1'b1, "rst_final round_final");
    #2 reset = 1'b1;
    #1 chk_reset("rst_mid_final");
    @(posedge clk);
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (14) begin @(negedge clk); seen = seen | out_valid[0]; end
    chkb(seen, 1'b0, "rst no out_valid");
    chki(hs[0], h, "rst handshakes");
    run_block(0, 1'b1, CT1, PT, "post_reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
